// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared constants and types for the RSA decryption datapath
//                (modular multiplier, reducer, exponentiation control).
//                RSA_WIDTH     - operand/modulus width
//                RSA_ACC_WIDTH - intermediate accumulator width (two guard bits)
//                rsa_state_e   - common IDLE/STEP/REDUCE sequencing states
//  Revision    : 1.0 - initial release
// ============================================================================
package rsa_pkg;

   localparam int RSA_WIDTH     = 1024;
   localparam int RSA_ACC_WIDTH = RSA_WIDTH + 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STEP   = 2'd1,
      REDUCE = 2'd2
   } rsa_state_e;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/mod_csub.sv
`default_nettype none
// ============================================================================
//  Module      : mod_csub
//  Description : Combinational conditional subtractor. Reduces an
//                accumulator known to be below 3n into [0, n) by subtracting
//                0, n or 2n.
//  Ports       : p_i  [WIDTH+1:0]  accumulator to reduce
//                n_i  [WIDTH-1:0]  modulus
//                p_o  [WIDTH+1:0]  p_i - k*n, k in {0,1,2}
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_csub
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic [WIDTH+1:0] p_i,
   input  logic [WIDTH-1:0] n_i,
   output logic [WIDTH+1:0] p_o
);

   logic [WIDTH+1:0] n1_w;
   logic [WIDTH+1:0] n2_w;
   logic [WIDTH+1:0] sub1_w;
   logic [WIDTH+1:0] sub2_w;

   // 2n fits in WIDTH+1 bits, so both multiples share the accumulator width.
   assign n1_w   = {2'b00, n_i};
   assign n2_w   = {1'b0, n_i, 1'b0};
   assign sub1_w = p_i - n1_w;
   assign sub2_w = p_i - n2_w;

   always_comb begin
      p_o = p_i;
      if (p_i >= n2_w) begin
         p_o = sub2_w;
      end else if (p_i >= n1_w) begin
         p_o = sub1_w;
      end
   end

endmodule : mod_csub
`default_nettype wire

// File: rtl/mod_mult_il.sv
`default_nettype none
// ============================================================================
//  Module      : mod_mult_il
//  Description : Interleaved (shift-add) modular multiplier computing
//                result = (a * b) mod n. The multiplier b is scanned MSB
//                first; each bit takes one STEP cycle (P = 2P + b[i]*a) and
//                one REDUCE cycle (P brought back below n), so a product is
//                ready 2*WIDTH cycles after the accepting start edge.
//  Ports       : clk     rising-edge clock
//                rst     synchronous active-high reset
//                start   request, sampled only while idle
//                a, b, n operands and modulus (a < n, b < n expected)
//                result  (a*b) mod n, valid while done is high
//                done    completion flag, held until next start or rst
//                busy    multiplication in progress
//                err     n == 0 was captured (asserted together with done)
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_mult_il
   import rsa_pkg::*;
#(
   parameter int WIDTH = RSA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy,
   output logic             err
);

   localparam int ACC_W = WIDTH + 2;
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   rsa_state_e        state_q,  state_d;
   logic [WIDTH-1:0]  a_q,      a_d;
   logic [WIDTH-1:0]  b_q,      b_d;
   logic [WIDTH-1:0]  n_q,      n_d;
   logic [ACC_W-1:0]  p_q,      p_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic              done_q,   done_d;
   logic              busy_q,   busy_d;
   logic              err_q,    err_d;

   logic [ACC_W-1:0]  p_red_w;
   logic [ACC_W-1:0]  addend_w;

   mod_csub #(
      .WIDTH (WIDTH)
   ) u_csub (
      .p_i (p_q),
      .n_i (n_q),
      .p_o (p_red_w)
   );

   assign addend_w = b_q[cnt_q] ? {2'b00, a_q} : '0;

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      n_d      = n_q;
      p_d      = p_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      done_d   = done_q;
      busy_d   = busy_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               n_d     = n;
               p_d     = '0;
               cnt_d   = CNT_W'(WIDTH - 1);
               done_d  = 1'b0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = STEP;
            end
         end

         STEP: begin
            if (n_q == '0) begin
               // Degenerate modulus: finish at once with an error flag.
               result_d = '0;
               done_d   = 1'b1;
               err_d    = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               // With P < n on entry this stays below 3n, inside ACC_W bits.
               p_d     = {p_q[ACC_W-2:0], 1'b0} + addend_w;
               state_d = REDUCE;
            end
         end

         REDUCE: begin
            p_d = p_red_w;
            if (cnt_q == '0) begin
               result_d = p_red_w[WIDTH-1:0];
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d   = cnt_q - 1'b1;
               state_d = STEP;
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         n_q      <= '0;
         p_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         n_q      <= n_d;
         p_q      <= p_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign result = result_q;
   assign done   = done_q;
   assign busy   = busy_q;
   assign err    = err_q;

endmodule : mod_mult_il
`default_nettype wire

// File: tb/tb_mod_mult_il.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_mult_il
//  Description : Directed testbench for mod_mult_il at WIDTH=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_mult_il;

   localparam int W    = 8;
   localparam int LAT  = 2 * W;
   localparam int BUDG = 40;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] n;
   logic [W-1:0] result;
   logic         done;
   logic         busy;
   logic         err;

   int pass_cnt;
   int total_cnt;
   int cyc_cnt;
   int t0;

   mod_mult_il #(
      .WIDTH (W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .n      (n),
      .result (result),
      .done   (done),
      .busy   (busy),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Drives a one-cycle start from a point just after an edge; t0 marks edge 0.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] nv);
      a = av; b = bv; n = nv; start = 1'b1;
      @(posedge clk); #1;
      t0 = cyc_cnt;
      start = 1'b0;
   endtask

   // Returns edges from edge 0 until done is seen (-1 on timeout) and
   // whether busy stayed high on every cycle before done.
   task automatic wait_done(output int cyc, output bit busy_ok);
      int i;
      cyc = -1;
      busy_ok = 1'b1;
      i = 0;
      while (cyc < 0 && i < BUDG) begin
         if (done) cyc = cyc_cnt - t0;
         else begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
         end
         i++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; a = '0; b = '0; n = '0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({result, done, busy, err} !== {8'd0, 3'b000})
         $display("FAIL reset_state: got result=%0d done=%b busy=%b err=%b, want 0/0/0/0",
                  result, done, busy, err);
      else pass_cnt++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cyc; bit bok;
      start_op(8'd5, 8'd7, 8'd11);
      total_cnt++;
      if (busy !== 1'b1 || done !== 1'b0)
         $display("FAIL basic_accept: got busy=%b done=%b, want 1/0", busy, done);
      else pass_cnt++;
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc !== LAT) $display("FAIL basic_latency: got %0d, want %0d", cyc, LAT);
      else pass_cnt++;
      total_cnt++;
      if (!bok) $display("FAIL basic_busy: busy dropped before done, want held high");
      else pass_cnt++;
      total_cnt++;
      if (result !== 8'd2 || err !== 1'b0 || busy !== 1'b0)
         $display("FAIL basic_result: got result=%0d err=%b busy=%b, want 2/0/0",
                  result, err, busy);
      else pass_cnt++;
   endtask

   task automatic test_vectors();
      logic [W-1:0] va [5] = '{8'd250, 8'd0,   8'd1,   8'd254, 8'd0};
      logic [W-1:0] vb [5] = '{8'd250, 8'd200, 8'd123, 8'd254, 8'd0};
      logic [W-1:0] vn [5] = '{8'd251, 8'd251, 8'd251, 8'd255, 8'd1};
      logic [W-1:0] ve [5] = '{8'd1,   8'd0,   8'd123, 8'd1,   8'd0};
      int cyc; bit bok;
      for (int k = 0; k < 5; k++) begin
         start_op(va[k], vb[k], vn[k]);
         wait_done(cyc, bok);
         total_cnt++;
         if (cyc !== LAT || result !== ve[k] || err !== 1'b0)
            $display("FAIL vector_%0d: got result=%0d lat=%0d err=%b, want %0d/%0d/0",
                     k, result, cyc, err, ve[k], LAT);
         else pass_cnt++;
      end
   endtask

   task automatic test_n_zero();
      int cyc; bit bok;
      start_op(8'd3, 8'd4, 8'd0);
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc !== 1 || err !== 1'b1 || result !== 8'd0 || busy !== 1'b0)
         $display("FAIL n_zero: got lat=%0d err=%b result=%0d busy=%b, want 1/1/0/0",
                  cyc, err, result, busy);
      else pass_cnt++;
      start_op(8'd3, 8'd4, 8'd11);
      total_cnt++;
      if (err !== 1'b0 || done !== 1'b0)
         $display("FAIL n_zero_clear: got err=%b done=%b, want 0/0", err, done);
      else pass_cnt++;
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc !== LAT || result !== 8'd1 || err !== 1'b0)
         $display("FAIL n_zero_recover: got result=%0d lat=%0d err=%b, want 1/%0d/0",
                  result, cyc, err, LAT);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int cyc; bit bok;
      start_op(8'd5, 8'd7, 8'd11);
      repeat (3) @(posedge clk);
      #1;
      // Second request during the operation, with different operands left on
      // the bus afterwards: neither may disturb the product in flight.
      a = 8'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; b = 8'd1; n = 8'd13;
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc !== LAT || result !== 8'd2)
         $display("FAIL ignore_start: got result=%0d lat=%0d, want 2/%0d", result, cyc, LAT);
      else pass_cnt++;
      start_op(8'd9, 8'd9, 8'd11);
      total_cnt++;
      if (done !== 1'b0 || busy !== 1'b1)
         $display("FAIL b2b_accept: got done=%b busy=%b, want 0/1", done, busy);
      else pass_cnt++;
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc !== LAT || result !== 8'd4)
         $display("FAIL b2b_result: got result=%0d lat=%0d, want 4/%0d", result, cyc, LAT);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int cyc; bit bok;
      start_op(8'd5, 8'd7, 8'd11);
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total_cnt++;
      if ({result, done, busy, err} !== {8'd0, 3'b000})
         $display("FAIL reset_mid: got result=%0d done=%b busy=%b err=%b, want 0/0/0/0",
                  result, done, busy, err);
      else pass_cnt++;
      // rst and start on the same edge: rst wins, nothing starts.
      a = 8'd3; b = 8'd4; n = 8'd11; start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_priority: got busy=%b done=%b, want 0/0", busy, done);
      else pass_cnt++;
      start_op(8'd6, 8'd7, 8'd11);
      wait_done(cyc, bok);
      total_cnt++;
      if (cyc !== LAT || result !== 8'd9)
         $display("FAIL reset_recover: got result=%0d lat=%0d, want 9/%0d", result, cyc, LAT);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int cyc; bit bok;
      int nv, av, bv, ev;
      for (int k = 0; k < 20; k++) begin
         nv = $urandom_range(255, 1);
         av = $urandom_range(nv - 1, 0);
         bv = $urandom_range(nv - 1, 0);
         ev = (av * bv) % nv;
         start_op(W'(av), W'(bv), W'(nv));
         wait_done(cyc, bok);
         total_cnt++;
         if (cyc !== LAT || result !== W'(ev))
            $display("FAIL random_%0d: a=%0d b=%0d n=%0d got result=%0d lat=%0d, want %0d/%0d",
                     k, av, bv, nv, result, cyc, ev, LAT);
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      t0        = 0;
      test_reset();
      test_basic();
      test_vectors();
      test_n_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_mod_mult_il
`default_nettype wire
